memory_debug_cmd_seq: RTL and testbench

Command sequencer upstream of the memory debugger read/write engine. It debounces board pushbuttons and switch settings and turns them into the debugger's level handshakes. It drives `read_do`, `read_do_next` and `write_do`, presenting them with stable, latched address/count/clear operands. It tracks `ready_for_next` to know when each operation has been accepted and finished, and offers a manual or timed auto-step mode for read walks.

---
 rtl/memory_debug_cmd_seq_if.sv | 37 +++
 rtl/memory_debug_cmd_seq.sv | 258 +++++++++++++++++++++++++
 tb/tb_memory_debug_cmd_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/memory_debug_cmd_seq_if.sv
// Level-handshake bundle between the command sequencer and the memory
// debugger read/write engine, including the latched operand buses.
interface memory_debug_cmd_seq_if;
   logic       read_do;
   logic       read_do_next;
   logic       write_do;
   logic [8:0] read_start_address;
   logic [8:0] read_num;
   logic [8:0] write_start_address;
   logic [8:0] write_num;
   logic       write_clear;
   logic       ready_for_next;

   modport master (
      output read_do,
      output read_do_next,
      output write_do,
      output read_start_address,
      output read_num,
      output write_start_address,
      output write_num,
      output write_clear,
      input  ready_for_next
   );

   modport slave (
      input  read_do,
      input  read_do_next,
      input  write_do,
      input  read_start_address,
      input  read_num,
      input  write_start_address,
      input  write_num,
      input  write_clear,
      output ready_for_next
   );
endinterface

// File: rtl/memory_debug_cmd_seq.sv
// Debounces board buttons and turns them into registered read/write/next
// handshakes for the memory debugger, with latched operands and auto-step.
module memory_debug_cmd_seq #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DB_W            = 20,
   parameter int PULSE_CYCLES    = 4,
   parameter int GAP_CYCLES      = 4,
   parameter int STEP_CYCLES     = 25000000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          btn_read,
   input  logic                          btn_write,
   input  logic                          btn_next,
   input  logic [8:0]                    sw_addr,
   input  logic [8:0]                    sw_num,
   input  logic                          sw_clear,
   input  logic                          sw_auto,
   memory_debug_cmd_seq_if.master        dbg,
   output logic                          busy,
   output logic [8:0]                    step_count
);

   localparam int PH_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX);
   localparam int TMR_W  = $clog2(STEP_CYCLES);

   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PH_W-1:0]  PULSE_LAST = PH_W'(PULSE_CYCLES - 1);
   localparam logic [PH_W-1:0]  GAP_LAST   = PH_W'(GAP_CYCLES - 1);
   localparam logic [TMR_W-1:0] STEP_LAST  = TMR_W'(STEP_CYCLES - 1);

   localparam int BTN_RD = 0;
   localparam int BTN_WR = 1;
   localparam int BTN_NX = 2;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_PULSE = 3'd1,
      S_RD_WAIT  = 3'd2,
      S_NEXT_HI  = 3'd3,
      S_NEXT_LO  = 3'd4,
      S_WR_PULSE = 3'd5,
      S_WR_WAIT  = 3'd6
   } state_t;

   state_t            state_r;
   state_t            state_nx;
   logic [2:0]        btn_raw_s;
   logic [2:0]        sync1_r;
   logic [2:0]        sync2_r;
   logic [2:0]        db_r;
   logic [2:0]        press_r;
   logic [DB_W-1:0]   db_cnt_r [3];
   logic [PH_W-1:0]   ph_cnt_r;
   logic [TMR_W-1:0]  tmr_r;
   logic              acked_r;
   logic              step_trig_s;
   logic              ready_s;
   logic              read_do_r;
   logic              read_do_next_r;
   logic              write_do_r;
   logic              busy_r;
   logic [8:0]        step_count_r;
   logic [8:0]        rd_addr_r;
   logic [8:0]        rd_num_r;
   logic [8:0]        wr_addr_r;
   logic [8:0]        wr_num_r;
   logic              wr_clear_r;

   assign btn_raw_s = {btn_next, btn_write, btn_read};
   assign ready_s   = dbg.ready_for_next;

   // Two-flop synchronizer, consecutive-cycle debouncer and one-cycle press flag per button
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 3'b000;
         sync2_r <= 3'b000;
         db_r    <= 3'b000;
         press_r <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            db_cnt_r[i] <= {DB_W{1'b0}};
         end
      end else begin
         sync1_r <= btn_raw_s;
         sync2_r <= sync1_r;
         for (int i = 0; i < 3; i++) begin
            if (sync2_r[i] == db_r[i]) begin
               db_cnt_r[i] <= {DB_W{1'b0}};
               press_r[i]  <= 1'b0;
            end else if (db_cnt_r[i] == DB_LAST) begin
               db_cnt_r[i] <= {DB_W{1'b0}};
               db_r[i]     <= sync2_r[i];
               press_r[i]  <= sync2_r[i];
            end else begin
               db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
               press_r[i]  <= 1'b0;
            end
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // Next-state decode; done wins over a step trigger in the same cycle
   always_comb begin
      state_nx    = state_r;
      step_trig_s = 1'b0;
      if (sw_auto) begin
         step_trig_s = (tmr_r == STEP_LAST);
      end else begin
         step_trig_s = press_r[BTN_NX];
      end
      case (state_r)
         S_IDLE: begin
            if (press_r[BTN_RD] && ready_s) begin
               state_nx = S_RD_PULSE;
            end else if (press_r[BTN_WR] && ready_s) begin
               state_nx = S_WR_PULSE;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_RD_PULSE: begin
            if (ph_cnt_r == PULSE_LAST) begin
               state_nx = S_RD_WAIT;
            end else begin
               state_nx = S_RD_PULSE;
            end
         end
         S_RD_WAIT: begin
            if (acked_r && ready_s) begin
               state_nx = S_IDLE;
            end else if (step_trig_s) begin
               state_nx = S_NEXT_HI;
            end else begin
               state_nx = S_RD_WAIT;
            end
         end
         S_NEXT_HI: begin
            if (ph_cnt_r == PULSE_LAST) begin
               state_nx = S_NEXT_LO;
            end else begin
               state_nx = S_NEXT_HI;
            end
         end
         S_NEXT_LO: begin
            if (ph_cnt_r == GAP_LAST) begin
               state_nx = S_RD_WAIT;
            end else begin
               state_nx = S_NEXT_LO;
            end
         end
         S_WR_PULSE: begin
            if (ph_cnt_r == PULSE_LAST) begin
               state_nx = S_WR_WAIT;
            end else begin
               state_nx = S_WR_PULSE;
            end
         end
         S_WR_WAIT: begin
            if (acked_r && ready_s) begin
               state_nx = S_IDLE;
            end else begin
               state_nx = S_WR_WAIT;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Phase/step timers, ack tracking, operand latches and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         ph_cnt_r       <= {PH_W{1'b0}};
         tmr_r          <= {TMR_W{1'b0}};
         acked_r        <= 1'b0;
         read_do_r      <= 1'b0;
         read_do_next_r <= 1'b0;
         write_do_r     <= 1'b0;
         busy_r         <= 1'b0;
         step_count_r   <= 9'd0;
         rd_addr_r      <= 9'd0;
         rd_num_r       <= 9'd0;
         wr_addr_r      <= 9'd0;
         wr_num_r       <= 9'd0;
         wr_clear_r     <= 1'b0;
      end else begin
         if (state_nx != state_r) begin
            ph_cnt_r <= {PH_W{1'b0}};
         end else begin
            ph_cnt_r <= ph_cnt_r + PH_W'(1);
         end

         // Auto-step period is measured rising edge to rising edge of read_do_next
         if ((state_r == S_RD_PULSE && state_nx == S_RD_WAIT) ||
             (state_r != S_NEXT_HI && state_nx == S_NEXT_HI)) begin
            tmr_r <= {TMR_W{1'b0}};
         end else if (tmr_r != STEP_LAST) begin
            tmr_r <= tmr_r + TMR_W'(1);
         end else begin
            tmr_r <= tmr_r;
         end

         if (state_r == S_IDLE && (state_nx == S_RD_PULSE || state_nx == S_WR_PULSE)) begin
            acked_r <= 1'b0;
         end else if ((state_r == S_RD_WAIT || state_r == S_WR_WAIT) && !ready_s) begin
            acked_r <= 1'b1;
         end else begin
            acked_r <= acked_r;
         end

         if (state_r == S_IDLE && state_nx == S_RD_PULSE) begin
            rd_addr_r    <= sw_addr;
            rd_num_r     <= sw_num;
            step_count_r <= 9'd0;
         end else if (state_r != S_NEXT_HI && state_nx == S_NEXT_HI) begin
            step_count_r <= step_count_r + 9'd1;
         end else begin
            step_count_r <= step_count_r;
         end

         if (state_r == S_IDLE && state_nx == S_WR_PULSE) begin
            wr_addr_r  <= sw_addr;
            wr_num_r   <= sw_num;
            wr_clear_r <= sw_clear;
         end else begin
            wr_clear_r <= wr_clear_r;
         end

         read_do_r      <= (state_nx == S_RD_PULSE);
         write_do_r     <= (state_nx == S_WR_PULSE);
         read_do_next_r <= (state_nx == S_NEXT_HI);
         busy_r         <= (state_nx != S_IDLE);
      end
   end

   assign dbg.read_do             = read_do_r;
   assign dbg.read_do_next        = read_do_next_r;
   assign dbg.write_do            = write_do_r;
   assign dbg.read_start_address  = rd_addr_r;
   assign dbg.read_num            = rd_num_r;
   assign dbg.write_start_address = wr_addr_r;
   assign dbg.write_num           = wr_num_r;
   assign dbg.write_clear         = wr_clear_r;
   assign busy                    = busy_r;
   assign step_count              = step_count_r;

endmodule

// File: tb/tb_memory_debug_cmd_seq.sv
// Directed bench for memory_debug_cmd_seq with a small debugger model that
// drops ready_for_next on each command and raises it once the work is done.
module tb_memory_debug_cmd_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_read = 1'b0;
   logic       btn_write = 1'b0;
   logic       btn_next = 1'b0;
   logic [8:0] sw_addr = 9'd0;
   logic [8:0] sw_num = 9'd0;
   logic       sw_clear = 1'b0;
   logic       sw_auto = 1'b0;
   logic       busy;
   logic [8:0] step_count;
   logic       rdy = 1'b1;

   int checks = 0;
   int errors = 0;

   memory_debug_cmd_seq_if dbg_if();

   memory_debug_cmd_seq #(
      .DEBOUNCE_CYCLES(8),
      .DB_W(20),
      .PULSE_CYCLES(2),
      .GAP_CYCLES(2),
      .STEP_CYCLES(20)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_read(btn_read),
      .btn_write(btn_write),
      .btn_next(btn_next),
      .sw_addr(sw_addr),
      .sw_num(sw_num),
      .sw_clear(sw_clear),
      .sw_auto(sw_auto),
      .dbg(dbg_if),
      .busy(busy),
      .step_count(step_count)
   );

   assign dbg_if.ready_for_next = rdy;

   always #5 clk = ~clk;

   // debugger model + edge monitor
   logic m_rd_q = 1'b0, m_wr_q = 1'b0, m_nx_q = 1'b0;
   int   m_mode = 0, m_need = 0, m_cnt = 0;
   int   cyc = 0;
   int   rd_rises = 0, wr_rises = 0, nx_rises = 0;
   int   rd_rise_t = 0, rd_fall_t = 0, wr_rise_t = 0, wr_fall_t = 0;
   int   nx_rise_t = 0, nx_prev_t = 0;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      m_rd_q <= dbg_if.read_do;
      m_wr_q <= dbg_if.write_do;
      m_nx_q <= dbg_if.read_do_next;
      if (dbg_if.read_do && !m_rd_q) begin rd_rises <= rd_rises + 1; rd_rise_t <= cyc; end
      if (!dbg_if.read_do && m_rd_q) rd_fall_t <= cyc;
      if (dbg_if.write_do && !m_wr_q) begin wr_rises <= wr_rises + 1; wr_rise_t <= cyc; end
      if (!dbg_if.write_do && m_wr_q) wr_fall_t <= cyc;
      if (dbg_if.read_do_next && !m_nx_q) begin
         nx_rises  <= nx_rises + 1;
         nx_prev_t <= nx_rise_t;
         nx_rise_t <= cyc;
      end
      if (rst) begin
         rdy <= 1'b1; m_mode <= 0; m_need <= 0; m_cnt <= 0;
      end else if (dbg_if.read_do && !m_rd_q) begin
         rdy <= 1'b0; m_mode <= 1; m_need <= int'(dbg_if.read_num) + 1; m_cnt <= 0;
      end else if (dbg_if.write_do && !m_wr_q) begin
         rdy <= 1'b0; m_mode <= 2; m_cnt <= int'(dbg_if.write_num) + 1;
      end else if (m_mode == 1 && dbg_if.read_do_next && !m_nx_q) begin
         if (m_cnt + 1 == m_need) begin rdy <= 1'b1; m_mode <= 0; end
         m_cnt <= m_cnt + 1;
      end else if (m_mode == 2) begin
         if (m_cnt <= 1) begin rdy <= 1'b1; m_mode <= 0; end
         else m_cnt <= m_cnt - 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      bit found;
      tick(3);
      // reset state
      chk("rst_read_do", 32'(dbg_if.read_do), 32'd0);
      chk("rst_write_do", 32'(dbg_if.write_do), 32'd0);
      chk("rst_read_do_next", 32'(dbg_if.read_do_next), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_step_count", 32'(step_count), 32'd0);
      chk("rst_operands", 32'({dbg_if.read_start_address, dbg_if.read_num,
                               dbg_if.write_start_address[4:0]}), 32'd0);
      chk("rst_wr_ops", 32'({dbg_if.write_num, dbg_if.write_clear}), 32'd0);
      rst = 1'b0;
      tick(2);

      // T1: bouncing read button, then stable high
      sw_addr = 9'h010; sw_num = 9'd2; sw_auto = 1'b0;
      for (int i = 0; i < 7; i++) begin
         btn_read = (i % 2 == 0);
         tick(3);
      end
      btn_read = 1'b1;
      tick(30);
      chk("t1_read_pulses", rd_rises, 32'd1);
      chk("t1_read_width", rd_fall_t - rd_rise_t, 32'd2);
      chk("t1_rd_addr", 32'(dbg_if.read_start_address), 32'h010);
      chk("t1_rd_num", 32'(dbg_if.read_num), 32'd2);
      chk("t1_busy", 32'(busy), 32'd1);
      btn_read = 1'b0;
      tick(15);
      // write press while busy is discarded
      btn_write = 1'b1; tick(15); btn_write = 1'b0; tick(15);
      chk("t1_no_write_busy", wr_rises, 32'd0);
      chk("t1_still_busy", 32'(busy), 32'd1);

      // T2: three manual next presses finish the read
      for (int k = 0; k < 3; k++) begin
         btn_next = 1'b1; tick(15); btn_next = 1'b0; tick(15);
         chk("t2_step_count", 32'(step_count), 32'(k + 1));
         chk("t2_next_pulses", nx_rises, 32'(k + 1));
      end
      chk("t2_ready", 32'(dbg_if.ready_for_next), 32'd1);
      chk("t2_busy_low", 32'(busy), 32'd0);
      btn_next = 1'b1; tick(15); btn_next = 1'b0; tick(15);
      chk("t2_fourth_ignored", nx_rises, 32'd3);
      chk("t2_step_hold", 32'(step_count), 32'd3);
      chk("t2_idle", 32'(busy), 32'd0);

      // T3: auto mode, single step
      sw_auto = 1'b1; sw_num = 9'd0; sw_addr = 9'h1F0;
      btn_read = 1'b1; tick(15); btn_read = 1'b0; tick(60);
      chk("t3_read_pulses", rd_rises, 32'd2);
      chk("t3_next_pulses", nx_rises, 32'd4);
      chk("t3_first_step", nx_rise_t - rd_fall_t, 32'd20);
      chk("t3_step_count", 32'(step_count), 32'd1);
      chk("t3_rd_addr", 32'(dbg_if.read_start_address), 32'h1F0);
      chk("t3_busy_low", 32'(busy), 32'd0);
      tick(40);
      chk("t3_no_extra_step", nx_rises, 32'd4);

      // T4: simultaneous read+write, auto mode with two steps
      sw_num = 9'd1; sw_addr = 9'h0C3;
      btn_read = 1'b1; btn_write = 1'b1; tick(15);
      btn_read = 1'b0; btn_write = 1'b0; tick(70);
      chk("t4_read_pulses", rd_rises, 32'd3);
      chk("t4_write_dropped", wr_rises, 32'd0);
      chk("t4_next_pulses", nx_rises, 32'd6);
      chk("t4_step_period", nx_rise_t - nx_prev_t, 32'd20);
      chk("t4_step_count", 32'(step_count), 32'd2);
      chk("t4_busy_low", 32'(busy), 32'd0);

      // T5: write with switch motion mid-operation
      sw_auto = 1'b0; sw_addr = 9'h0AB; sw_num = 9'd4; sw_clear = 1'b1;
      btn_write = 1'b1; tick(12);
      btn_write = 1'b0; sw_addr = 9'h155; sw_num = 9'd7; sw_clear = 1'b0;
      chk("t5_busy_mid", 32'(busy), 32'd1);
      chk("t5_wr_num_mid", 32'(dbg_if.write_num), 32'd4);
      chk("t5_wr_clear_mid", 32'(dbg_if.write_clear), 32'd1);
      tick(25);
      chk("t5_write_pulses", wr_rises, 32'd1);
      chk("t5_write_width", wr_fall_t - wr_rise_t, 32'd2);
      chk("t5_busy_low", 32'(busy), 32'd0);
      chk("t5_wr_addr", 32'(dbg_if.write_start_address), 32'h0AB);
      chk("t5_wr_num", 32'(dbg_if.write_num), 32'd4);
      chk("t5_wr_clear", 32'(dbg_if.write_clear), 32'd1);
      chk("t5_rd_num_kept", 32'(dbg_if.read_num), 32'd1);

      // T6: reset during S_NEXT_HI
      sw_addr = 9'h022; sw_num = 9'd1;
      btn_read = 1'b1; tick(15); btn_read = 1'b0; tick(5);
      btn_next = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 25 && !found; i++) begin
         tick(1);
         if (dbg_if.read_do_next) found = 1'b1;
      end
      chk("t6_next_hi_seen", 32'(found), 32'd1);
      rst = 1'b1;
      tick(1);
      chk("t6_rst_handshakes", 32'({dbg_if.read_do, dbg_if.read_do_next, dbg_if.write_do}), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_step_count", 32'(step_count), 32'd0);
      chk("t6_rst_rd_ops", 32'({dbg_if.read_start_address, dbg_if.read_num}), 32'd0);
      chk("t6_rst_wr_ops", 32'({dbg_if.write_start_address, dbg_if.write_num, dbg_if.write_clear}), 32'd0);
      rst = 1'b0; btn_next = 1'b0;
      tick(15);
      btn_read = 1'b1; tick(15); btn_read = 1'b0; tick(3);
      chk("t6_read_after_rst", rd_rises, 32'd5);
      chk("t6_rd_addr", 32'(dbg_if.read_start_address), 32'h022);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
